adc_capture_nch: RTL and testbench

Parametrised multi-channel ADC capture and conditioning stage. It registers NCH parallel ADC sample words through a configurable-depth register chain. Each sample can be converted from offset-binary to two's complement. Output is one of four modes: pass-through, boxcar averaging, decimation or hold, with a sample-valid qualifier. It sits between the ADC interface pins and the TMU/PID datapath and generalises the fixed two-channel, 12-bit, two-stage input register.

---
 rtl/adc_capture_nch.sv | 121 ++++++++++++
 tb/tb_adc_capture_nch.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_nch.sv
// Multi-channel ADC capture: STAGES-deep input register chain, optional offset-binary
// to two's-complement conversion, then a pass-through / average / decimate / hold output stage.
module adc_capture_nch #(
  parameter int NCH      = 2,
  parameter int DW       = 12,
  parameter int STAGES   = 2,
  parameter int AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH*DW-1:0] adc_data_in,
  input  logic              adc_valid_in,
  input  logic [1:0]        mode,
  input  logic              signed_en,
  output logic [NCH*DW-1:0] adc_data_out,
  output logic              adc_valid_out
);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_AVG  = 2'b01;
  localparam logic [1:0] MODE_DEC  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam int AW = DW + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  logic [NCH*DW-1:0]      dat_chain [STAGES];
  logic [STAGES-1:0]      vld_chain;
  logic [1:0]             mode_q;
  logic                   signed_q;
  logic                   cfg_chg_q;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [NCH-1:0][AW-1:0] acc, acc_nxt, ext, sum;
  logic [NCH-1:0][DW-1:0] conv, avg;
  logic [NCH*DW-1:0]      dat_nxt;
  logic                   vld_nxt;
  logic                   exit_vld;
  logic                   windowed;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) dat_chain[i] <= '0;
      vld_chain <= '0;
      mode_q    <= MODE_PASS;
      signed_q  <= 1'b0;
      cfg_chg_q <= 1'b0;
    end else begin
      dat_chain[0] <= adc_data_in;
      vld_chain[0] <= adc_valid_in;
      for (int i = 1; i < STAGES; i++) begin
        dat_chain[i] <= dat_chain[i-1];
        vld_chain[i] <= vld_chain[i-1];
      end
      mode_q    <= mode;
      signed_q  <= signed_en;
      // Marks the first cycle in which mode_q/signed_q carry a new configuration.
      cfg_chg_q <= (mode != mode_q) || (signed_en != signed_q);
    end
  end

  assign exit_vld = vld_chain[STAGES-1];
  assign windowed = (AVG_LOG2 > 0) && ((mode_q == MODE_AVG) || (mode_q == MODE_DEC));

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      conv[k] = dat_chain[STAGES-1][k*DW +: DW] ^ {signed_q, {(DW-1){1'b0}}};
      ext[k]  = signed_q ? AW'($signed(conv[k])) : AW'(conv[k]);
      sum[k]  = acc[k] + ext[k];
      // Upper DW bits equal both the logical and the arithmetic shift by AVG_LOG2.
      avg[k]  = sum[k][AW-1:AVG_LOG2];
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    acc_nxt = acc;
    dat_nxt = adc_data_out;
    vld_nxt = 1'b0;
    if (mode_q == MODE_HOLD) begin
      cnt_nxt = '0;
      acc_nxt = '0;
    end else if (!windowed) begin
      cnt_nxt = '0;
      acc_nxt = '0;
      if (exit_vld) begin
        vld_nxt = 1'b1;
        dat_nxt = conv;
      end
    end else if (cfg_chg_q) begin
      // A new configuration restarts the window; this sample becomes its first entry.
      cnt_nxt = exit_vld ? CW'(1) : '0;
      acc_nxt = (exit_vld && (mode_q == MODE_AVG)) ? ext : '0;
    end else if (exit_vld) begin
      if (cnt == CNT_LAST) begin
        vld_nxt = 1'b1;
        dat_nxt = (mode_q == MODE_AVG) ? avg : conv;
        cnt_nxt = '0;
        acc_nxt = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
        if (mode_q == MODE_AVG) acc_nxt = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      acc           <= '0;
      adc_data_out  <= '0;
      adc_valid_out <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      acc           <= acc_nxt;
      adc_data_out  <= dat_nxt;
      adc_valid_out <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_adc_capture_nch.sv
// Bench for adc_capture_nch: directed scenarios plus random traffic, all checked
// against a window-queue reference model driven by the per-cycle input history.
module tb_adc_capture_nch;
  localparam int NCH = 2, DW = 12, STAGES = 2, AVG_LOG2 = 2;
  localparam int W = NCH * DW;
  localparam int N = 1 << AVG_LOG2;
  localparam int HMAX = 8192;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] adc_data_in;
  logic         adc_valid_in;
  logic [1:0]   mode;
  logic         signed_en;
  logic [W-1:0] adc_data_out;
  logic         adc_valid_out;

  adc_capture_nch #(.NCH(NCH), .DW(DW), .STAGES(STAGES), .AVG_LOG2(AVG_LOG2)) dut (
    .clk(clk), .rst(rst), .adc_data_in(adc_data_in), .adc_valid_in(adc_valid_in),
    .mode(mode), .signed_en(signed_en), .adc_data_out(adc_data_out), .adc_valid_out(adc_valid_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit [W-1:0] h_dat [HMAX];
  bit         h_vld [HMAX];
  bit [2:0]   h_cfg [HMAX];
  int         cyc_n = STAGES + 2;
  bit [W-1:0] win [$];
  logic [W-1:0] exp_dat;
  logic         exp_vld;

  function automatic logic [W-1:0] window_mean(input bit sgn);
    logic [W-1:0] r;
    bit [W-1:0] e;
    int s, q, v;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      s = 0;
      for (int i = 0; i < win.size(); i++) begin
        e = win[i];
        v = int'(e[k*DW +: DW]);
        if (sgn && v >= (1 << (DW-1))) v -= (1 << DW);
        s += v;
      end
      q = s / N;
      if ((s % N) != 0 && s < 0) q -= 1;
      r[k*DW +: DW] = q[DW-1:0];
    end
    return r;
  endfunction

  // One clock: drive inputs, let the edge pass, then advance the reference model.
  task automatic cyc(input bit r, input bit v, input logic [W-1:0] d, input logic [1:0] m, input bit s);
    bit [2:0] cfg, pcfg;
    bit [W-1:0] x;
    bit sv;
    rst = r; adc_valid_in = v; adc_data_in = d; mode = m; signed_en = s;
    @(posedge clk); #1;
    cyc_n++;
    h_dat[cyc_n] = d; h_vld[cyc_n] = v; h_cfg[cyc_n] = {m, s};
    exp_vld = 1'b0;
    if (r) begin
      for (int i = 0; i < STAGES; i++) h_vld[cyc_n-i] = 1'b0;
      h_cfg[cyc_n] = 3'b000;
      win.delete();
      exp_dat = '0;
    end else begin
      cfg  = h_cfg[cyc_n-1];
      pcfg = h_cfg[cyc_n-2];
      if (cfg != pcfg) win.delete();
      sv = h_vld[cyc_n-STAGES];
      x  = h_dat[cyc_n-STAGES];
      if (cfg[0]) for (int k = 0; k < NCH; k++) x[k*DW+DW-1] = ~x[k*DW+DW-1];
      case (cfg[2:1])
        2'b11: win.delete();
        2'b00: if (sv) begin exp_vld = 1'b1; exp_dat = x; end
        default: if (sv) begin
          win.push_back(x);
          if (win.size() == N) begin
            exp_vld = 1'b1;
            exp_dat = (cfg[2:1] == 2'b01) ? window_mean(cfg[0]) : x;
            win.delete();
          end
        end
      endcase
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, i[0], W'($urandom()), 2'b00, 1'b0);
      vectors++;
      if (adc_valid_out !== 1'b0 || adc_data_out !== '0) begin
        miscompares++;
        $display("FAIL reset cyc%0d: valid=%b data=%h, required 0/0", i, adc_valid_out, adc_data_out);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, i == 0, W'(24'h5A5A5A), 2'b00, 1'b0);
      vectors++;
      if (adc_valid_out !== (i == 2) || adc_valid_out !== exp_vld || adc_data_out !== exp_dat) begin
        miscompares++;
        $display("FAIL post_reset cyc%0d: valid=%b data=%h, required %b/%h", i, adc_valid_out, adc_data_out, exp_vld, exp_dat);
      end
    end
  endtask

  task automatic test_pass();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, i == 0, {12'hABC, 12'h123}, 2'b00, 1'b0);
      vectors++;
      if (adc_valid_out !== (i == 2) || (i == 2 && adc_data_out !== {12'hABC, 12'h123})) begin
        miscompares++;
        $display("FAIL pass cyc%0d: valid=%b data=%h, required valid=%b data=abc123", i, adc_valid_out, adc_data_out, i == 2);
      end
    end
  endtask

  task automatic test_avg_unsigned();
    logic [11:0] ch0 [4] = '{12'd10, 12'd11, 12'd12, 12'd14};
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 2'b01, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, i < 4, (i < 4) ? {12'hFFF, ch0[i & 3]} : W'(0), 2'b01, 1'b0);
      vectors++;
      if (adc_valid_out !== (i == 5) || (i == 5 && adc_data_out !== {12'hFFF, 12'd11})) begin
        miscompares++;
        $display("FAIL avg_unsigned cyc%0d: valid=%b data=%h, required valid=%b data=fff00b", i, adc_valid_out, adc_data_out, i == 5);
      end
    end
  endtask

  task automatic test_avg_signed();
    logic [11:0] ch0 [8] = '{12'h7FF, 12'h7FF, 12'h7FF, 12'h7FE, 12'h800, 12'h800, 12'h800, 12'h800};
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 2'b01, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, i < 8, (i < 8) ? {12'h800, ch0[i & 7]} : W'(0), 2'b01, 1'b1);
      vectors++;
      if (adc_valid_out !== (i == 5 || i == 9) ||
          (i == 5 && adc_data_out !== {12'h000, 12'hFFE}) ||
          (i == 9 && adc_data_out !== '0)) begin
        miscompares++;
        $display("FAIL avg_signed cyc%0d: valid=%b data=%h", i, adc_valid_out, adc_data_out);
      end
    end
  endtask

  task automatic test_decimate();
    int pulses = 0;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, '0, 2'b10, 1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, i < 8, (i < 8) ? W'(i + 1) : W'(0), 2'b10, 1'b0);
      if (adc_valid_out === 1'b1) pulses++;
      vectors++;
      if (adc_valid_out !== (i == 5 || i == 9) ||
          (i == 5 && adc_data_out !== W'(4)) || (i == 9 && adc_data_out !== W'(8))) begin
        miscompares++;
        $display("FAIL decimate cyc%0d: valid=%b data=%h", i, adc_valid_out, adc_data_out);
      end
    end
    vectors++;
    if (pulses != 2) begin
      miscompares++;
      $display("FAIL decimate_pulses: got %0d, required 2", pulses);
    end
  endtask

  task automatic test_disrupt_mode();
    logic [1:0] m;
    bit v;
    logic [W-1:0] d;
    for (int i = 0; i < 19; i++) begin
      m = (i >= 5 && i <= 8) ? 2'b00 : 2'b01;
      v = (i < 2) || (i == 5) || (i >= 12 && i <= 15);
      d = (i == 0) ? W'(5) : (i == 1) ? W'(7) : (i == 5) ? {12'h055, 12'h099} : {12'd20, 12'd20};
      cyc(1'b0, v, d, m, 1'b0);
      vectors++;
      if (adc_valid_out !== (i == 7 || i == 17) ||
          (i == 7 && adc_data_out !== {12'h055, 12'h099}) ||
          (i == 17 && adc_data_out !== {12'd20, 12'd20}) ||
          adc_valid_out !== exp_vld || adc_data_out !== exp_dat) begin
        miscompares++;
        $display("FAIL disrupt_mode cyc%0d: valid=%b data=%h, model %b/%h", i, adc_valid_out, adc_data_out, exp_vld, exp_dat);
      end
    end
  endtask

  task automatic test_disrupt_reset();
    bit v;
    for (int i = 0; i < 20; i++) begin
      v = (i < 2) || (i >= 10 && i <= 11) || (i >= 15 && i <= 16);
      cyc(i == 5, v, (i < 2) ? W'(5 + 2 * i) : {12'd20, 12'd20}, 2'b01, 1'b0);
      vectors++;
      if (adc_valid_out !== (i == 18) || (i == 18 && adc_data_out !== {12'd20, 12'd20})) begin
        miscompares++;
        $display("FAIL disrupt_reset cyc%0d: valid=%b data=%h, required valid=%b", i, adc_valid_out, adc_data_out, i == 18);
      end
    end
  endtask

  task automatic test_back_to_back();
    int run = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, '0, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, i < 6, W'($urandom()), 2'b00, 1'b0);
      if (adc_valid_out === 1'b1) run++;
      vectors++;
      if (adc_valid_out !== exp_vld || adc_data_out !== exp_dat) begin
        miscompares++;
        $display("FAIL back_to_back cyc%0d: got %b/%h, required %b/%h", i, adc_valid_out, adc_data_out, exp_vld, exp_dat);
      end
    end
    vectors++;
    if (run != 6) begin
      miscompares++;
      $display("FAIL back_to_back_count: got %0d pulses, required 6", run);
    end
  endtask

  task automatic test_random();
    logic [1:0] m = 2'b01;
    bit s = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) m = 2'($urandom());
      if ($urandom_range(31) == 0) s = ~s;
      cyc($urandom_range(199) == 0, $urandom_range(9) < 7, W'($urandom()), m, s);
      vectors++;
      if (adc_valid_out !== exp_vld || adc_data_out !== exp_dat) begin
        miscompares++;
        $display("FAIL random cyc%0d mode=%b sgn=%b: got %b/%h, required %b/%h", i, m, s, adc_valid_out, adc_data_out, exp_vld, exp_dat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_avg_unsigned();
    test_avg_signed();
    test_decimate();
    test_disrupt_mode();
    test_disrupt_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
